vga_scanout_fsm: RTL and testbench

- Display-side consumer of the PPU frame buffer. Generates 640x480@60 VGA timing from `clk` via a pixel-tick divider.
- Reads the 256x240 PPU frame buffer, doubling each pixel horizontally and vertically into a 512x480 window centred on screen. Outputs palette indices plus sync signals.
- Owns the `vga_done` handshake. Low means scanout owns frame-buffer reads. High means the PPU may render and write the buffer.

---
 rtl/vga_scanout_fsm.sv | 159 +++++++++++++++
 tb/tb_vga_scanout_fsm.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vga_scanout_fsm.sv
// VGA 640x480 scanout of a 256x240 frame buffer, pixel-doubled into a centred 512x480 window.
// Owns the vga_done handshake that hands frame-buffer write ownership to the PPU.
module vga_scanout_fsm #(
  parameter int          CLK_DIV    = 2,
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          X_OFFSET   = 64,
  parameter logic [5:0]  BORDER_IDX = 6'h0F
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] fb_addr,
  output logic        fb_rd_en,
  input  logic [7:0]  fb_rd_data,
  output logic        vga_done,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank,
  output logic [5:0]  vga_color_idx,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int TW      = $clog2(CLK_DIV);

  typedef enum logic {ST_DONE, ST_SCAN} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic [15:0]   fb_addr_q, fb_addr_d;
  logic          fb_rd_en_q, fb_rd_en_d;
  logic          rd_dly_q, rd_dly_d;
  logic [5:0]    pix_q, pix_d;
  logic          p_win_q, p_win_d, p_act_q, p_act_d, p_hs_q, p_hs_d, p_vs_q, p_vs_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
  logic [5:0]    color_q, color_d;
  logic          frame_start_q, frame_start_d;

  logic       tick, active, window, hs_raw, vs_raw, h_last, v_last;
  logic [9:0] col_diff;
  logic [5:0] pix_now;
  logic       unused_bits;

  always_comb begin
    tick     = (tick_q == TW'(CLK_DIV - 1));
    active   = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
    window   = active && (h_q >= 10'(X_OFFSET)) && (h_q < 10'(X_OFFSET + 512));
    col_diff = h_q - 10'(X_OFFSET);
    hs_raw   = !((h_q >= 10'(H_ACTIVE + H_FP)) && (h_q < 10'(H_ACTIVE + H_FP + H_SYNC)));
    vs_raw   = !((v_q >= 10'(V_ACTIVE + V_FP)) && (v_q < 10'(V_ACTIVE + V_FP + V_SYNC)));
    h_last   = (h_q == 10'(H_TOTAL - 1));
    v_last   = (v_q == 10'(V_TOTAL - 1));
    // Read data lands one clk after the strobe; hold it until the next tick consumes it.
    pix_now  = rd_dly_q ? fb_rd_data[5:0] : pix_q;

    state_d       = state_q;
    tick_d        = tick ? '0 : tick_q + TW'(1);
    h_d           = h_q;
    v_d           = v_q;
    fb_addr_d     = fb_addr_q;
    fb_rd_en_d    = 1'b0;
    rd_dly_d      = fb_rd_en_q;
    pix_d         = pix_now;
    p_win_d       = p_win_q;
    p_act_d       = p_act_q;
    p_hs_d        = p_hs_q;
    p_vs_d        = p_vs_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_d       = blank_q;
    color_d       = color_q;
    frame_start_d = 1'b0;

    if (tick) begin
      h_d = h_last ? 10'd0 : h_q + 10'd1;
      if (h_last) v_d = v_last ? 10'd0 : v_q + 10'd1;

      fb_rd_en_d = window;
      if (window) fb_addr_d = {v_q[8:1], col_diff[8:1]};

      p_win_d = window;
      p_act_d = active;
      p_hs_d  = hs_raw;
      p_vs_d  = vs_raw;

      hsync_d = p_hs_q;
      vsync_d = p_vs_q;
      blank_d = !p_act_q;
      color_d = p_win_q ? pix_now : (p_act_q ? BORDER_IDX : 6'd0);

      // The wrap tick that produces h=0,v=0 hands the buffer back to scanout.
      if (h_last && v_last) begin
        state_d       = ST_SCAN;
        frame_start_d = 1'b1;
      end else if ((v_q == 10'(V_ACTIVE - 1)) && (h_q == 10'(X_OFFSET + 512))) begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_DONE;
      tick_q        <= '0;
      h_q           <= 10'd0;
      v_q           <= 10'(V_ACTIVE);
      fb_addr_q     <= 16'd0;
      fb_rd_en_q    <= 1'b0;
      rd_dly_q      <= 1'b0;
      pix_q         <= 6'd0;
      p_win_q       <= 1'b0;
      p_act_q       <= 1'b0;
      p_hs_q        <= 1'b1;
      p_vs_q        <= 1'b1;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_q       <= 1'b1;
      color_q       <= 6'd0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      h_q           <= h_d;
      v_q           <= v_d;
      fb_addr_q     <= fb_addr_d;
      fb_rd_en_q    <= fb_rd_en_d;
      rd_dly_q      <= rd_dly_d;
      pix_q         <= pix_d;
      p_win_q       <= p_win_d;
      p_act_q       <= p_act_d;
      p_hs_q        <= p_hs_d;
      p_vs_q        <= p_vs_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      color_q       <= color_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign unused_bits   = ^{fb_rd_data[7:6], col_diff[9], col_diff[0]};
  assign vga_done      = (state_q == ST_DONE);
  assign fb_addr       = fb_addr_q;
  assign fb_rd_en      = fb_rd_en_q;
  assign vga_hsync     = hsync_q;
  assign vga_vsync     = vsync_q;
  assign vga_blank     = blank_q;
  assign vga_color_idx = color_q;
  assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_vga_scanout_fsm.sv
// Bench for vga_scanout_fsm: a shortened frame geometry keeps a full frame plus a mid-frame
// reset within budget; expected outputs come from frame-position arithmetic over tick counts.
module tb_vga_scanout_fsm;

  localparam int D        = 3;
  localparam int H_ACTIVE = 640, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_ACTIVE = 12,  V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int X_OFF    = 64;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;
  localparam int START    = V_ACTIVE * H_TOTAL;
  localparam int SET_POS  = (V_ACTIVE - 1) * H_TOTAL + X_OFF + 512;

  typedef struct packed {
    logic        rd_en;
    logic [15:0] addr;
    logic        done;
    logic        hs;
    logic        vs;
    logic        blank;
    logic [5:0]  color;
    logic        fs;
  } out_t;
  localparam int OW = $bits(out_t);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] fb_addr;
  logic        fb_rd_en;
  logic [7:0]  fb_rd_data = 8'd0;
  logic        vga_done, vga_hsync, vga_vsync, vga_blank, frame_start;
  logic [5:0]  vga_color_idx;

  logic [7:0]    mem [0:65535];
  logic [OW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;

  vga_scanout_fsm #(
    .CLK_DIV(D), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .X_OFFSET(X_OFF), .BORDER_IDX(6'h0F)
  ) dut (
    .clk(clk), .rst(rst), .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .fb_rd_data(fb_rd_data),
    .vga_done(vga_done), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank),
    .vga_color_idx(vga_color_idx), .frame_start(frame_start)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Frame-buffer memory: one clk read latency.
  always @(posedge clk) if (fb_rd_en) fb_rd_data <= mem[fb_addr];

  // ---------------- reference model ----------------
  function automatic int pos(input int k);
    return ((START + k) % FRAME + FRAME) % FRAME;
  endfunction
  function automatic bit is_active(input int p);
    return (p % H_TOTAL) < H_ACTIVE && (p / H_TOTAL) < V_ACTIVE;
  endfunction
  function automatic bit is_window(input int p);
    return is_active(p) && (p % H_TOTAL) >= X_OFF && (p % H_TOTAL) < X_OFF + 512;
  endfunction
  function automatic logic [15:0] addr_of(input int p);
    int row, col;
    row = (p / H_TOTAL) / 2;
    col = ((p % H_TOTAL) - X_OFF) / 2;
    return {row[7:0], col[7:0]};
  endfunction

  int          n_edges = 0;
  logic [15:0] last_addr = 16'd0;

  always @(posedge clk) begin
    out_t e;
    int   t, c, q;
    bit   tick_edge;
    #1;
    if (!rst) begin
      n_edges   = 0;
      last_addr = 16'd0;
      e = '{rd_en: 1'b0, addr: 16'd0, done: 1'b1, hs: 1'b1, vs: 1'b1, blank: 1'b1,
            color: 6'd0, fs: 1'b0};
    end else begin
      n_edges++;
      t         = n_edges / D;
      tick_edge = (n_edges % D) == 0;
      c         = pos(t - 1);
      q         = pos(t - 2);
      e.rd_en   = tick_edge && is_window(c);
      if (e.rd_en) last_addr = addr_of(c);
      e.addr    = last_addr;
      e.done    = !(c == FRAME - 1 || c < SET_POS);
      e.fs      = tick_edge && (c == FRAME - 1);
      e.hs      = !((q % H_TOTAL) >= H_ACTIVE + H_FP && (q % H_TOTAL) < H_ACTIVE + H_FP + H_SYNC);
      e.vs      = !((q / H_TOTAL) >= V_ACTIVE + V_FP && (q / H_TOTAL) < V_ACTIVE + V_FP + V_SYNC);
      e.blank   = !is_active(q);
      e.color   = is_window(q) ? mem[addr_of(q)][5:0] : (is_active(q) ? 6'h0F : 6'd0);
    end
    exp_q.push_back(e);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    out_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("fb_rd_en",      32'(fb_rd_en),      32'(e.rd_en));
      check("fb_addr",       32'(fb_addr),       32'(e.addr));
      check("vga_done",      32'(vga_done),      32'(e.done));
      check("vga_hsync",     32'(vga_hsync),     32'(e.hs));
      check("vga_vsync",     32'(vga_vsync),     32'(e.vs));
      check("vga_blank",     32'(vga_blank),     32'(e.blank));
      check("vga_color_idx", 32'(vga_color_idx), 32'(e.color));
      check("frame_start",   32'(frame_start),   32'(e.fs));
      check("rd_while_done", 32'(fb_rd_en && vga_done), 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));

    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1 check("done_after_reset", 32'(vga_done), 32'd1);

    // Clocks from reset release to the first frame_start.
    cnt = 0;
    while (cnt < 3 * FRAME * D) begin
      @(posedge clk);
      cnt++;
      #1;
      if (frame_start) break;
    end
    check("first_frame_start_clks", 32'(cnt), 32'((V_TOTAL - V_ACTIVE) * H_TOTAL * D));

    // One full frame, then into line 2 of the next before an asynchronous reset.
    repeat ((FRAME + 2 * H_TOTAL + 300) * D) @(posedge clk);
    @(negedge clk);
    #1 check("done_low_mid_frame", 32'(vga_done), 32'd0);
    check("blank_low_mid_frame", 32'(vga_blank), 32'd0);
    rst = 1'b0;
    #1;
    check("async_done",   32'(vga_done),      32'd1);
    check("async_blank",  32'(vga_blank),     32'd1);
    check("async_hsync",  32'(vga_hsync),     32'd1);
    check("async_vsync",  32'(vga_vsync),     32'd1);
    check("async_color",  32'(vga_color_idx), 32'd0);
    check("async_rd_en",  32'(fb_rd_en),      32'd0);
    check("async_addr",   32'(fb_addr),       32'd0);
    check("async_fstart", 32'(frame_start),   32'd0);

    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    repeat (2000 * D) @(posedge clk);
    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
